sid_reg_ctrl: RTL
=================

Name: sid_reg_ctrl

Overview:
- Host-side register controller for the three-voice SID tone/envelope datapath.
- Accepts byte writes through a valid/ready handshake into a small write FIFO, then drains them into the SID register file at one write per cycle while `hold` is low.
- Drives the per-voice `freq`/`pw`/`ctrl`/`atk_dec`/`sus_rel` inputs and the filter/volume registers.
- Serves registered readback of OSC3/ENV3.

Parameters:
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- wr_valid  in  1  host write request
- wr_ready  out  1  FIFO can accept a write this cycle
- wr_addr  in  5  SID register address
- wr_data  in  8  write byte
- rd_en  in  1  read strobe
- rd_addr  in  5  read address
- rd_data  out  8  read result, registered
- hold  in  1  stall FIFO drain (e.g. during datapath reset or sequencing)
- busy  out  1  FIFO non-empty
- osc3  in  8  voice-3 sample upper bits (sample3[11:4])
- ch3_env  in  8  voice-3 envelope level
- freq1, freq2, freq3  out  16  voice frequency
- pw1, pw2, pw3  out  12  pulse width
- ctrl_reg1, ctrl_reg2, ctrl_reg3  out  8  voice control
- atk_dec1, atk_dec2, atk_dec3  out  8  attack/decay
- sus_rel1, sus_rel2, sus_rel3  out  8  sustain/release
- fc  out  11  filter cutoff
- res_filt  out  8  resonance/filter routing
- mode_vol  out  8  filter mode/master volume

Behaviour:
- Reset (async, rst=1): all register outputs 0, FIFO empty, rd_data=0, busy=0, wr_ready=1 from the first cycle after reset release.
- Handshake:
  - A push occurs on a rising clk edge when wr_valid && wr_ready.
  - wr_ready = (count != FIFO_DEPTH), combinational from count only.
  - wr_addr/wr_data are held by the host until accepted.
- Drain:
  - When count != 0 and hold == 0, the head entry is popped and applied to the register file on the same edge.
  - Effect is visible on the outputs the cycle after the pop edge.
  - Minimum write-to-output latency is 2 cycles (push edge, then pop edge).
- Simultaneous push+pop (count not full): count unchanged, both take effect.
- Full: no push possible, even if a pop occurs that cycle; wr_ready reasserts the cycle after the pop.
- hold=1: FIFO contents frozen; pushes still accepted while not full.
- Address map (voice v base = 0x00, 0x07, 0x0E):
  - base+0: freq[7:0]
  - base+1: freq[15:8]
  - base+2: pw[7:0]
  - base+3: pw[11:8] ← data[3:0]; data[7:4] discarded
  - base+4: ctrl_reg
  - base+5: atk_dec
  - base+6: sus_rel
  - 0x15: fc[2:0] ← data[2:0]
  - 0x16: fc[10:3] ← data
  - 0x17: res_filt
  - 0x18: mode_vol
  - 0x19–0x1F: write popped, no effect.
- Byte writes modify only the addressed byte/field; other bits are held.
- Read:
  - On rd_en, rd_data updates on the next edge: 0x1B → osc3, 0x1C → ch3_env, all other addresses → 0x00.
  - Without rd_en, rd_data holds its value.
  - Reads never touch the FIFO.
- busy = (count != 0), registered consistent with count.
- FIFO pointers wrap modulo FIFO_DEPTH; count is a log2(FIFO_DEPTH)+1-bit counter.
- Reset asserted mid-operation: all pending FIFO entries are discarded, and registers return to 0 immediately (asynchronous).

Test Plan:
- Reset, then write 0x00=0x34, 0x01=0x12, hold=0 → freq1=0x1234 after last pop; busy low 1 cycle after final pop.
- Write 0x0A (pw2 hi)=0xFF after 0x09=0xAB → pw2=0xFAB; no other output changes.
- hold=1, push 4 writes → wr_ready=0 after the 4th, 5th wr_valid stalls; release hold → one pop per cycle, wr_ready=1 the cycle after the first pop; 5th write applied last, in order.
- hold=0, continuous push every cycle → steady state count≤1, wr_ready never drops; writes to 0x0E–0x14 set all voice-3 outputs to the pushed values.
- osc3=0x5A, ch3_env=0xC3: rd_en at 0x1B → rd_data=0x5A next cycle; at 0x1C → 0xC3; at 0x04 → 0x00; rd_en=0 → rd_data holds.
- Write 0x15=0xFF, 0x16=0x80 → fc=0x407; write 0x1D=0x55 → no output change; assert rst with 3 queued entries → outputs 0 immediately, busy=0, queued writes never applied.

Source files
------------

// File: rtl/sid_reg_ctrl_if.sv
// Host-side bus bundle for the SID register controller.
// Carries the byte-write valid/ready handshake and the registered readback port.
interface sid_reg_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;

  // Host side: issues writes and read strobes.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_data
  );

  // Controller side: accepts writes and returns read data.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_en, rd_addr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/sid_reg_ctrl.sv
// SID register controller.
// Host byte writes are queued in a small FIFO and drained into the SID register
// file at one write per cycle whenever hold is low. OSC3/ENV3 readback is
// registered. All state is cleared asynchronously by rst.
module sid_reg_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sid_reg_ctrl_if.slave        bus,
  input  logic                 hold,
  output logic                 busy,
  input  logic [7:0]           osc3,
  input  logic [7:0]           ch3_env,
  output logic [15:0]          freq1,
  output logic [15:0]          freq2,
  output logic [15:0]          freq3,
  output logic [11:0]          pw1,
  output logic [11:0]          pw2,
  output logic [11:0]          pw3,
  output logic [7:0]           ctrl_reg1,
  output logic [7:0]           ctrl_reg2,
  output logic [7:0]           ctrl_reg3,
  output logic [7:0]           atk_dec1,
  output logic [7:0]           atk_dec2,
  output logic [7:0]           atk_dec3,
  output logic [7:0]           sus_rel1,
  output logic [7:0]           sus_rel2,
  output logic [7:0]           sus_rel3,
  output logic [10:0]          fc,
  output logic [7:0]           res_filt,
  output logic [7:0]           mode_vol
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Write FIFO storage and bookkeeping
  logic [4:0]    fifo_addr_r [FIFO_DEPTH];
  logic [7:0]    fifo_data_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          busy_r;
  logic          wr_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [4:0]    head_addr_s;
  logic [7:0]    head_data_s;

  // Head-entry decode
  logic          voice_hit_s;
  logic [1:0]    voice_sel_s;
  logic [2:0]    voice_off_s;

  // SID register file
  logic [15:0]   freq_r    [3];
  logic [11:0]   pw_r      [3];
  logic [7:0]    ctrl_r    [3];
  logic [7:0]    atk_dec_r [3];
  logic [7:0]    sus_rel_r [3];
  logic [10:0]   fc_r;
  logic [7:0]    res_filt_r;
  logic [7:0]    mode_vol_r;
  logic [7:0]    rd_data_r;

  // wr_ready depends on the registered count only, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign wr_ready_s   = (count_r != DEPTH_C);
  assign push_s       = bus.wr_valid && wr_ready_s;
  assign pop_s        = (count_r != {CW{1'b0}}) && !hold;
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_data_s  = fifo_data_r[rd_ptr_r];

  // Next occupancy from the push/pop pair of this cycle
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO payload storage; needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
      fifo_data_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // FIFO pointers, occupancy and busy flag; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      busy_r  <= (count_nxt_s != {CW{1'b0}});
    end
  end

  // Split the head address into voice index and field offset.
  // Voice bases are 0, 7 and 14; since 7 == -1 and 14 == -2 modulo 8, the
  // 3-bit offset is the low address bits plus 0, 1 or 2 respectively.
  always_comb begin
    voice_hit_s = 1'b0;
    voice_sel_s = 2'd0;
    voice_off_s = 3'd0;
    if (head_addr_s < 5'd7) begin
      voice_hit_s = 1'b1;
      voice_sel_s = 2'd0;
      voice_off_s = head_addr_s[2:0];
    end else if (head_addr_s < 5'd14) begin
      voice_hit_s = 1'b1;
      voice_sel_s = 2'd1;
      voice_off_s = head_addr_s[2:0] + 3'd1;
    end else if (head_addr_s < 5'd21) begin
      voice_hit_s = 1'b1;
      voice_sel_s = 2'd2;
      voice_off_s = head_addr_s[2:0] + 3'd2;
    end else begin
      voice_hit_s = 1'b0;
      voice_sel_s = 2'd0;
      voice_off_s = 3'd0;
    end
  end

  // Apply the popped entry to the register file; only the addressed field changes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < 3; v++) begin
        freq_r[v]    <= 16'h0000;
        pw_r[v]      <= 12'h000;
        ctrl_r[v]    <= 8'h00;
        atk_dec_r[v] <= 8'h00;
        sus_rel_r[v] <= 8'h00;
      end
      fc_r       <= 11'h000;
      res_filt_r <= 8'h00;
      mode_vol_r <= 8'h00;
    end else if (pop_s) begin
      if (voice_hit_s) begin
        case (voice_off_s)
          3'd0:    freq_r[voice_sel_s][7:0]  <= head_data_s;
          3'd1:    freq_r[voice_sel_s][15:8] <= head_data_s;
          3'd2:    pw_r[voice_sel_s][7:0]    <= head_data_s;
          3'd3:    pw_r[voice_sel_s][11:8]   <= head_data_s[3:0];
          3'd4:    ctrl_r[voice_sel_s]       <= head_data_s;
          3'd5:    atk_dec_r[voice_sel_s]    <= head_data_s;
          3'd6:    sus_rel_r[voice_sel_s]    <= head_data_s;
          default: ;
        endcase
      end else begin
        case (head_addr_s)
          5'h15:   fc_r[2:0]  <= head_data_s[2:0];
          5'h16:   fc_r[10:3] <= head_data_s;
          5'h17:   res_filt_r <= head_data_s;
          5'h18:   mode_vol_r <= head_data_s;
          default: ;
        endcase
      end
    end
  end

  // Registered readback of voice-3 oscillator and envelope; holds without rd_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 8'h00;
    end else if (bus.rd_en) begin
      case (bus.rd_addr)
        5'h1B:   rd_data_r <= osc3;
        5'h1C:   rd_data_r <= ch3_env;
        default: rd_data_r <= 8'h00;
      endcase
    end
  end

  assign bus.wr_ready = wr_ready_s;
  assign bus.rd_data  = rd_data_r;
  assign busy         = busy_r;

  assign freq1     = freq_r[0];
  assign freq2     = freq_r[1];
  assign freq3     = freq_r[2];
  assign pw1       = pw_r[0];
  assign pw2       = pw_r[1];
  assign pw3       = pw_r[2];
  assign ctrl_reg1 = ctrl_r[0];
  assign ctrl_reg2 = ctrl_r[1];
  assign ctrl_reg3 = ctrl_r[2];
  assign atk_dec1  = atk_dec_r[0];
  assign atk_dec2  = atk_dec_r[1];
  assign atk_dec3  = atk_dec_r[2];
  assign sus_rel1  = sus_rel_r[0];
  assign sus_rel2  = sus_rel_r[1];
  assign sus_rel3  = sus_rel_r[2];
  assign fc        = fc_r;
  assign res_filt  = res_filt_r;
  assign mode_vol  = mode_vol_r;

endmodule
